// File: rtl/cmos_dvp_tx_pkg.sv
// Shared types and constants for the DVP transmitter (camera-bus sensor emulator).
package cmos_dvp_pkg;

  typedef enum logic [2:0] {IDLE, VSYNC, VBACK, ACTIVE, VFRONT} dvp_state_e;

  localparam int CNT_W = 12;
  localparam int LP    = 2 * 640 + 144;

  // Line period in clock cycles: two byte cycles per pixel plus horizontal blanking.
  function automatic int line_period(input int h_disp, input int h_blank);
    return 2 * h_disp + h_blank;
  endfunction

endpackage

// File: rtl/cmos_dvp_tx_if.sv
// Pixel-stream handshake and DVP byte bus; master is the transmitter side.
interface cmos_dvp_tx_if;
  import cmos_dvp_pkg::*;

  logic [15:0] iPIX_DATA;
  logic        iPIX_VALID;
  logic        oPIX_READY;
  logic        CMOS_VSYNC;
  logic        CMOS_HREF;
  logic [7:0]  CMOS_DATA;

  modport master (input iPIX_DATA, iPIX_VALID,
                  output oPIX_READY, CMOS_VSYNC, CMOS_HREF, CMOS_DATA);
  modport slave  (output iPIX_DATA, iPIX_VALID,
                  input oPIX_READY, CMOS_VSYNC, CMOS_HREF, CMOS_DATA);

endinterface

// File: rtl/cmos_dvp_tx_timing.sv
// Frame/line sequencer: state machine plus h/v counters, producing registered sync strobes.
module cmos_dvp_timing
  import cmos_dvp_pkg::*;
#(
  parameter int H_DISP   = 640,
  parameter int V_DISP   = 480,
  parameter int H_BLANK  = 144,
  parameter int VS_LINES = 4,
  parameter int VB_LINES = 16,
  parameter int VF_LINES = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic en_i,
  output logic vsync_o,
  output logic href_o,
  output logic byte_phase_o,
  output logic ready_next_o,
  output logic frame_start_o,
  output logic frame_end_o
);

  localparam int              LINE_LEN  = line_period(H_DISP, H_BLANK);
  localparam logic [CNT_W-1:0] LAST_H    = CNT_W'(LINE_LEN - 1);
  localparam logic [CNT_W-1:0] ACT_BYTES = CNT_W'(2 * H_DISP);

  dvp_state_e       state_q, state_d;
  logic [CNT_W-1:0] hCnt_q, hCnt_d;
  logic [CNT_W-1:0] vCnt_q, vCnt_d;
  logic [CNT_W-1:0] lastLine;
  logic             lineEnd;

  // Counters describe the position shown on the bus one cycle later, so registering
  // from the _q side lines up with the bus and from the _d side gives one cycle of lookahead.
  always_comb begin
    state_d  = state_q;
    hCnt_d   = hCnt_q;
    vCnt_d   = vCnt_q;
    lineEnd  = (hCnt_q == LAST_H);
    lastLine = CNT_W'(VF_LINES - 1);
    case (state_q)
      VSYNC:   lastLine = CNT_W'(VS_LINES - 1);
      VBACK:   lastLine = CNT_W'(VB_LINES - 1);
      ACTIVE:  lastLine = CNT_W'(V_DISP - 1);
      default: ;
    endcase
    if (state_q == IDLE) begin
      if (en_i) begin
        state_d = VSYNC;
        hCnt_d  = '0;
        vCnt_d  = '0;
      end
    end else begin
      hCnt_d = lineEnd ? '0 : hCnt_q + 1'b1;
      if (lineEnd) begin
        if (vCnt_q == lastLine) begin
          vCnt_d = '0;
          case (state_q)
            VSYNC:   state_d = VBACK;
            VBACK:   state_d = ACTIVE;
            ACTIVE:  state_d = VFRONT;
            default: state_d = en_i ? VSYNC : IDLE;
          endcase
        end else begin
          vCnt_d = vCnt_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      hCnt_q        <= '0;
      vCnt_q        <= '0;
      vsync_o       <= 1'b1;
      href_o        <= 1'b0;
      byte_phase_o  <= 1'b0;
      ready_next_o  <= 1'b0;
      frame_start_o <= 1'b0;
      frame_end_o   <= 1'b0;
    end else begin
      state_q       <= state_d;
      hCnt_q        <= hCnt_d;
      vCnt_q        <= vCnt_d;
      vsync_o       <= (state_q == IDLE) || (state_q == VSYNC);
      href_o        <= (state_q == ACTIVE) && (hCnt_q < ACT_BYTES);
      ready_next_o  <= (state_d == ACTIVE) && (hCnt_d < ACT_BYTES) && !hCnt_d[0];
      byte_phase_o  <= (state_d == ACTIVE) && (hCnt_d < ACT_BYTES) && hCnt_d[0];
      frame_start_o <= (state_q == VSYNC) && (vCnt_q == '0) && (hCnt_q == '0);
      frame_end_o   <= (state_q == VFRONT) && lineEnd && (vCnt_q == lastLine);
    end
  end

endmodule

// File: rtl/cmos_dvp_tx.sv
// DVP transmitter top: RGB565 stream in, sensor-like VSYNC/HREF/byte bus out.
module cmos_dvp_tx
  import cmos_dvp_pkg::*;
#(
  parameter int H_DISP   = 640,
  parameter int V_DISP   = 480,
  parameter int H_BLANK  = 144,
  parameter int VS_LINES = 4,
  parameter int VB_LINES = 16,
  parameter int VF_LINES = 8
) (
  input  logic              iCLK,
  input  logic              iRST,
  input  logic              iEN,
  cmos_dvp_tx_if.master     bus,
  output logic              CMOS_PCLK,
  output logic              oFRAME_START,
  output logic              oUNDERRUN,
  output logic [7:0]        oFRAME_CNT
);

  logic       vsync, href, bytePhase, readyNext, frameEnd;
  logic [7:0] data_q, data_d, low_q, low_d, cnt_q, cnt_d;
  logic       under_q, under_d;

  cmos_dvp_timing #(
    .H_DISP(H_DISP), .V_DISP(V_DISP), .H_BLANK(H_BLANK),
    .VS_LINES(VS_LINES), .VB_LINES(VB_LINES), .VF_LINES(VF_LINES)
  ) u_timing (
    .clk          (iCLK),
    .rst          (iRST),
    .en_i         (iEN),
    .vsync_o      (vsync),
    .href_o       (href),
    .byte_phase_o (bytePhase),
    .ready_next_o (readyNext),
    .frame_start_o(oFRAME_START),
    .frame_end_o  (frameEnd)
  );

  // A missing pixel is sent as zero so the line keeps its timing.
  always_comb begin
    data_d  = '0;
    low_d   = low_q;
    under_d = 1'b0;
    cnt_d   = cnt_q;
    if (readyNext) begin
      data_d  = bus.iPIX_VALID ? bus.iPIX_DATA[15:8] : 8'h00;
      low_d   = bus.iPIX_VALID ? bus.iPIX_DATA[7:0]  : 8'h00;
      under_d = !bus.iPIX_VALID;
    end else if (bytePhase) begin
      data_d = low_q;
    end
    if (frameEnd) cnt_d = cnt_q + 8'd1;
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      data_q  <= '0;
      low_q   <= '0;
      under_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      data_q  <= data_d;
      low_q   <= low_d;
      under_q <= under_d;
      cnt_q   <= cnt_d;
    end
  end

  assign CMOS_PCLK      = ~iCLK;
  assign bus.CMOS_VSYNC = vsync;
  assign bus.CMOS_HREF  = href;
  assign bus.CMOS_DATA  = data_q;
  assign bus.oPIX_READY = readyNext;
  assign oUNDERRUN      = under_q;
  assign oFRAME_CNT     = cnt_q;

endmodule

// File: tb/tb_cmos_dvp_tx.sv
// Directed bench for cmos_dvp_tx on a small 98-cycle frame geometry.
module tb_cmos_dvp_tx;

  localparam int H_DISP    = 4;
  localparam int V_DISP    = 3;
  localparam int H_BLANK   = 6;
  localparam int VS_LINES  = 1;
  localparam int VB_LINES  = 2;
  localparam int VF_LINES  = 1;
  localparam int LP        = 2 * H_DISP + H_BLANK;
  localparam int ACT_START = (VS_LINES + VB_LINES) * LP;
  localparam int ACT_END   = ACT_START + V_DISP * LP;
  localparam int FRAME_LEN = ACT_END + VF_LINES * LP;
  localparam logic [20:0] RESET_VEC = 21'h100000;

  logic       iCLK = 1'b0;
  logic       iRST = 1'b1;
  logic       iEN  = 1'b0;
  logic       CMOS_PCLK, oFRAME_START, oUNDERRUN;
  logic [7:0] oFRAME_CNT;
  int         checks = 0;
  int         errors = 0;
  int         pixN   = 0;

  cmos_dvp_tx_if dvpIf ();

  cmos_dvp_tx #(
    .H_DISP(H_DISP), .V_DISP(V_DISP), .H_BLANK(H_BLANK),
    .VS_LINES(VS_LINES), .VB_LINES(VB_LINES), .VF_LINES(VF_LINES)
  ) dut (
    .iCLK        (iCLK),
    .iRST        (iRST),
    .iEN         (iEN),
    .bus         (dvpIf),
    .CMOS_PCLK   (CMOS_PCLK),
    .oFRAME_START(oFRAME_START),
    .oUNDERRUN   (oUNDERRUN),
    .oFRAME_CNT  (oFRAME_CNT)
  );

  always #5 iCLK = ~iCLK;

  function automatic logic [20:0] sampleBus();
    return {dvpIf.CMOS_VSYNC, dvpIf.CMOS_HREF, dvpIf.oPIX_READY, oFRAME_START,
            oUNDERRUN, dvpIf.CMOS_DATA, oFRAME_CNT};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic valid, input logic en);
    dvpIf.iPIX_VALID = valid;
    dvpIf.iPIX_DATA  = 16'(32'hA000 + pixN);
    iEN              = en;
    @(posedge iCLK);
    #1;
  endtask

  // Expected {vsync,href,ready,start,underrun,data,cnt} at frame cycle k; slot u is starved.
  function automatic logic [20:0] model(input int k, input int base, input int u, input logic [7:0] cnt);
    logic       vs, hr, rdy, st, und;
    logic [7:0] dat;
    logic [15:0] pix;
    int a, h, slot, k1;
    vs  = (k < VS_LINES * LP);
    hr  = 1'b0;
    rdy = 1'b0;
    st  = (k == 0);
    und = 1'b0;
    dat = 8'h00;
    if (k >= ACT_START && k < ACT_END) begin
      a = k - ACT_START;
      h = a % LP;
      if (h < 2 * H_DISP) begin
        hr   = 1'b1;
        slot = (a / LP) * H_DISP + h / 2;
        if (slot == u)               pix = 16'h0000;
        else if (u >= 0 && slot > u) pix = 16'(32'hA000 + base + slot - 1);
        else                         pix = 16'(32'hA000 + base + slot);
        dat = (h % 2 == 0) ? pix[15:8] : pix[7:0];
        und = (slot == u) && (h % 2 == 0);
      end
    end
    k1 = k + 1;
    if (k1 >= ACT_START && k1 < ACT_END) begin
      h   = (k1 - ACT_START) % LP;
      rdy = (h < 2 * H_DISP) && (h % 2 == 0);
    end
    return {vs, hr, rdy, st, und, dat, cnt};
  endfunction

  task automatic runFrame(input string name, input logic [7:0] cnt, input int u,
                          input int dropAt, input int len);
    int   base, uk;
    logic rdy, vld, en;
    base = pixN;
    uk   = (u >= 0) ? ACT_START + (u / H_DISP) * LP + (u % H_DISP) * 2 : -10;
    for (int k = 0; k < len; k++) begin
      checkOutput($sformatf("%s k%0d", name, k), {11'b0, sampleBus()},
                  {11'b0, model(k, base, u, cnt)});
      rdy = dvpIf.oPIX_READY;
      vld = !(k == uk - 1);
      en  = !(dropAt >= 0 && k >= dropAt);
      applyStimulus(vld, en);
      if (rdy && vld) pixN++;
    end
  endtask

  task automatic waitStart(input string name);
    logic found;
    found = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (oFRAME_START) begin
        found = 1'b1;
        break;
      end
      applyStimulus(1'b1, 1'b1);
    end
    checkOutput(name, {31'b0, found}, 32'd1);
  endtask

  initial begin
    dvpIf.iPIX_VALID = 1'b0;
    dvpIf.iPIX_DATA  = 16'h0000;
    repeat (2) @(posedge iCLK);
    #1;
    checkOutput("reset", {11'b0, sampleBus()}, {11'b0, RESET_VEC});
    iRST = 1'b0;
    repeat (3) applyStimulus(1'b1, 1'b0);
    checkOutput("idle before enable", {11'b0, sampleBus()}, {11'b0, RESET_VEC});

    waitStart("first start");
    runFrame("f0", 8'd0, -1, -1, FRAME_LEN);
    runFrame("f1 underrun", 8'd1, 1, -1, FRAME_LEN);
    runFrame("f2 en drop", 8'd2, -1, 60, FRAME_LEN);

    for (int i = 0; i < 20; i++) begin
      checkOutput($sformatf("idle after drop %0d", i), {11'b0, sampleBus()},
                  {11'b0, 1'b1, 4'b0000, 8'h00, 8'd3});
      applyStimulus(1'b1, 1'b0);
    end

    waitStart("restart");
    runFrame("f3 pre reset", 8'd3, -1, -1, ACT_START + 2 * LP + 3);
    #2 iRST = 1'b1;
    #1 checkOutput("async reset", {11'b0, sampleBus()}, {11'b0, RESET_VEC});
    @(posedge iCLK);
    #1 checkOutput("reset held", {11'b0, sampleBus()}, {11'b0, RESET_VEC});
    iRST = 1'b0;

    waitStart("start after reset");
    for (int f = 0; f <= 256; f++)
      runFrame($sformatf("w%0d", f), 8'(f), -1, (f == 256) ? 50 : -1, FRAME_LEN);
    checkOutput("idle after wrap", {11'b0, sampleBus()},
                {11'b0, 1'b1, 4'b0000, 8'h00, 8'd1});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    errors++;
    $display("[TB] FAIL watchdog got timeout expected finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
